// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main control state machine of the multicycle RV32I core. Steps each
// instruction through fetch, decode, execute, memory and writeback over the
// shared ALU, the unified memory port and the register file, and drives every
// datapath mux select and write enable. Immediate-select decode (ImmSrc) lives
// in a separate combinational block and is not produced here.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : ILLEGAL is a terminal trap state (illegal_instr=1, all enables
//               0) left only by reset; stores with funct3_b2=1 are also trapped.
//   undefined : ILLEGAL skips the instruction and returns to FETCH,
//               illegal_instr is tied 0 and funct3_b2 is ignored.
//
// Ports
//   clk           in   core clock, rising edge
//   rst_n         in   synchronous active-low reset
//   op[6:0]       in   opcode field of the instruction register
//   funct3_b2     in   instr[14], used only by the trap feature
//   mem_ready     in   memory access completes in this cycle
//   branch_taken  in   branch condition from the ALU flag logic
//   pc_write      out  PC register enable
//   adr_src       out  memory address select: 0 PC, 1 Result
//   mem_write     out  memory write strobe
//   ir_write      out  instruction/OldPC register enable
//   result_src    out  00 ALUOut, 01 Data, 10 ALUResult
//   alu_src_a     out  00 PC, 01 OldPC, 10 RD1
//   alu_src_b     out  00 RD2, 01 ImmExt, 10 constant 4
//   alu_op        out  00 add, 01 sub/compare, 10 funct-decoded, 11 pass B
//   reg_write     out  register file write enable
//   instret       out  retired-instruction count (wraps)
//   illegal_instr out  trap indication (only with ILLEGAL_TRAP_EN)
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic                 funct3_b2,
  input  logic                 mem_ready,
  input  logic                 branch_taken,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal_instr
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_JALR,
    S_JAL,
    S_BRANCH,
    S_LUI,
    S_AUIPC,
    S_ILLEGAL
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   pc_update;
  logic                   branch;
  logic                   retire;

`ifndef ILLEGAL_TRAP_EN
  logic unused_funct3_b2;
  assign unused_funct3_b2 = funct3_b2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    retire        = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;

    case (state_q)
      // PC+4 is computed here and written back together with the IR load,
      // both gated by the memory handshake.
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      // The branch target OldPC+imm is computed speculatively into ALUOut.
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD:   state_d = S_MEMADR;
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXEC_R;
          OP_ITYPE:  state_d = S_EXEC_I;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_BRANCH: state_d = S_BRANCH;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          default:   state_d = S_ILLEGAL;
        endcase
`ifdef ILLEGAL_TRAP_EN
        // Store funct3 values of 4 and above are not defined.
        if (op == OP_STORE && funct3_b2) state_d = S_ILLEGAL;
`endif
      end

      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      // The strobe is held until the memory accepts the write.
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      // rs1+imm overwrites the speculative branch target in ALUOut, then the
      // shared JAL state jumps to it.
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end

      // PC takes the target from ALUOut while the ALU forms OldPC+4, which
      // ALUWB then writes to rd.
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end

      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_LUI: begin
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        state_d   = S_ALUWB;
      end

      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        state_d   = S_ALUWB;
      end

      // PC was already advanced in FETCH, so skipping needs no extra work.
      S_ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b1;
        state_d       = S_ILLEGAL;
`else
        state_d       = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase

    pc_write  = pc_update | (branch & branch_taken);
    instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Self-checking bench for multicycle_ctrl_fsm (default build). Stimulus walks
// instructions through the core one cycle at a time; for every cycle it
// pushes the control word and instret count that instruction class should
// show in that step. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic       rw;
    logic       ill;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic        funct3_b2;
  logic        mem_ready;
  logic        branch_taken;
  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [31:0] instret;
  logic        illegal_instr;

  ctl_t        expCtl[$];
  logic [31:0] expRet[$];
  string       expName[$];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] retired = 0;

  multicycle_ctrl_fsm #(.INSTRET_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .funct3_b2    (funct3_b2),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .instret      (instret),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  function automatic ctl_t mk(input logic pcw, input logic adr, input logic mw,
                              input logic irw, input logic [1:0] rs,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [1:0] aop, input logic rw);
    ctl_t c;
    c.pcw = pcw; c.adr = adr; c.mw = mw; c.irw = irw; c.rs = rs;
    c.sa = sa; c.sb = sb; c.aop = aop; c.rw = rw; c.ill = 1'b0;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit isLegal(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
      7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compare one popped expectation against what the DUT shows now.
  task automatic checkOutput(input string name, input ctl_t e, input logic [31:0] r);
    ctl_t act;
    act = '{pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
            alu_src_b, alu_op, reg_write, illegal_instr};
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL ctl %s: got %b required %b (t=%0t)", name, act, e, $time);
    end
    checks++;
    if (instret !== r) begin
      failures++;
      $display("[TB] FAIL instret %s: got %0d required %0d (t=%0t)", name, instret, r, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expCtl.size() != 0) begin
      checkOutput(expName.pop_front(), expCtl.pop_front(), expRet.pop_front());
    end
  end

  // One cycle: drive the cycle-dependent inputs, record the expectation,
  // advance past the next rising edge.
  task automatic cyc(input string name, input ctl_t c, input logic rdy, input logic bt);
    mem_ready    = rdy;
    branch_taken = bt;
    funct3_b2    = rb();
    expName.push_back(name);
    expCtl.push_back(c);
    expRet.push_back(retired);
    @(posedge clk);
    #1;
  endtask

  // Run one instruction: fw wait cycles in fetch, mwt wait cycles in the
  // memory access, tk the branch outcome.
  task automatic applyStimulus(input logic [6:0] o, input int fw, input int mwt, input logic tk);
    ctl_t aluwb;
    aluwb = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
    op = o;
    for (int i = 0; i < fw; i++)
      cyc("FETCH_WAIT", mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), 1'b0, rb());
    cyc("FETCH", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0), 1'b1, rb());
    cyc("DECODE", mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0), rb(), rb());
    case (o)
      7'b0110011: begin
        cyc("EXEC_R", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0), rb(), rb());
        cyc("ALUWB", aluwb, rb(), rb()); retired++;
      end
      7'b0010011: begin
        cyc("EXEC_I", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0), rb(), rb());
        cyc("ALUWB", aluwb, rb(), rb()); retired++;
      end
      7'b0110111: begin
        cyc("LUI", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b11, 0), rb(), rb());
        cyc("ALUWB", aluwb, rb(), rb()); retired++;
      end
      7'b0010111: begin
        cyc("AUIPC", mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0), rb(), rb());
        cyc("ALUWB", aluwb, rb(), rb()); retired++;
      end
      7'b0000011: begin
        cyc("MEMADR", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), rb(), rb());
        for (int i = 0; i < mwt; i++)
          cyc("MEMREAD_WAIT", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1'b0, rb());
        cyc("MEMREAD", mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1'b1, rb());
        cyc("MEMWB", mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1), rb(), rb()); retired++;
      end
      7'b0100011: begin
        cyc("MEMADR", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), rb(), rb());
        for (int i = 0; i < mwt; i++)
          cyc("MEMWRITE_WAIT", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1'b0, rb());
        cyc("MEMWRITE", mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1'b1, rb()); retired++;
      end
      7'b1100011: begin
        cyc("BRANCH", mk(tk, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0), rb(), tk); retired++;
      end
      7'b1100111: begin
        cyc("JALR", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), rb(), rb());
        cyc("JAL", mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0), rb(), rb());
        cyc("ALUWB", aluwb, rb(), rb()); retired++;
      end
      7'b1101111: begin
        cyc("JAL", mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0), rb(), rb());
        cyc("ALUWB", aluwb, rb(), rb()); retired++;
      end
      default: begin
        cyc("ILLEGAL", mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), rb(), rb());
      end
    endcase
  endtask

  initial begin
    logic [6:0] legalOps [9];
    logic [6:0] o;
    legalOps = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                 7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};
    rst_n = 1'b0; op = 7'b0110011; funct3_b2 = 1'b0;
    mem_ready = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed instructions from the plan
    applyStimulus(7'b0110011, 0, 0, 1'b0);
    applyStimulus(7'b0000011, 0, 2, 1'b0);
    applyStimulus(7'b0100011, 0, 3, 1'b0);
    applyStimulus(7'b1100011, 0, 0, 1'b1);
    applyStimulus(7'b1100011, 0, 0, 1'b0);
    applyStimulus(7'b1100111, 0, 0, 1'b0);
    applyStimulus(7'b1101111, 1, 0, 1'b0);
    applyStimulus(7'b1111111, 0, 0, 1'b0);
    applyStimulus(7'b0010011, 2, 0, 1'b0);
    applyStimulus(7'b0110111, 0, 0, 1'b0);
    applyStimulus(7'b0010111, 0, 0, 1'b0);

    // Reset in the middle of a load: no write-back, count cleared
    op = 7'b0000011;
    cyc("FETCH", mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0), 1'b1, rb());
    cyc("DECODE", mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0), rb(), rb());
    rst_n = 1'b0;
    cyc("MEMADR_RST", mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0), rb(), rb());
    rst_n = 1'b1;
    retired = 0;
    applyStimulus(7'b0110011, 0, 0, 1'b0);

    // Randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do o = 7'($urandom_range(0, 127)); while (isLegal(o));
      end else begin
        o = legalOps[$urandom_range(0, 8)];
      end
      applyStimulus(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb());
    end

    repeat (4) begin
      if (expCtl.size() != 0) @(negedge clk);
    end
    if (expCtl.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expCtl.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, unified memory port and register file.
- Consumes the opcode from the instruction register and drives every datapath mux select and write enable.
- The immediate-select decode stays a separate combinational block; this FSM does not drive ImmSrc.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  7  opcode field of instruction register
- funct3_b2  in  1  instr[14], unused except under the optional feature
- mem_ready  in  1  memory handshake: access completes in this cycle
- branch_taken  in  1  branch condition result from ALU flag logic
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 PC, 1 Result
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction/OldPC register enable
- result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a  out  2  00 PC, 01 OldPC, 10 RD1
- alu_src_b  out  2  00 RD2, 01 ImmExt, 10 constant 4
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded, 11 pass B
- reg_write  out  1  register file write enable
- instret  out  INSTRET_W  retired-instruction count
- illegal_instr  out  1  only with optional feature; otherwise tied 0

Behaviour:
- The state register updates on the rising edge of clk.
- rst_n=0 at an edge: state:=FETCH and instret:=0. This holds mid-instruction; no partial writes are required to complete.
- Outputs are a Moore decode of state, gated by mem_ready where noted. Unlisted outputs are 0.
- pc_write = pc_update | (branch & branch_taken).
- States, outputs and transitions:
  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_update=mem_ready. Stay while !mem_ready, else go to DECODE.
  - DECODE: a=01, b=01, alu_op=00 (branch target into ALUOut). Next state by op: 0000011/0100011 MEMADR; 0110011 EXEC_R; 0010011 EXEC_I; 1101111 JAL; 1100111 JALR; 1100011 BRANCH; 0110111 LUI; 0010111 AUIPC; other ILLEGAL.
  - MEMADR: a=10, b=01, alu_op=00. Next MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Stay while !mem_ready, else MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write stays asserted until mem_ready, then FETCH.
  - EXEC_R: a=10, b=00, alu_op=10. Next ALUWB.
  - EXEC_I: a=10, b=01, alu_op=10. Next ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next FETCH.
  - JALR: a=10, b=01, alu_op=00 (target into ALUOut). Next JAL.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Next ALUWB (writes OldPC+4).
  - BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1. Next FETCH.
  - LUI: b=01, alu_op=11. Next ALUWB.
  - AUIPC: a=01, b=01, alu_op=00. Next ALUWB.
  - ILLEGAL: no enables asserted. Next FETCH; the instruction is skipped, and the PC was already advanced in FETCH.
- instret increments by 1 in the cycle the FSM leaves MEMWB, MEMWRITE (with mem_ready) or BRANCH, or leaves ALUWB. ILLEGAL does not count. Wraps to 0.
- Zero-wait latencies, fetch through final state:
  - R/I/LUI/AUIPC: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL: 4 cycles
  - JALR: 5 cycles
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle; no other state samples mem_ready.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - ILLEGAL is a terminal state that asserts illegal_instr=1 and holds all enables at 0 until rst_n=0.
  - Also trapped: a load/store with op valid but funct3_b2=1 on a store.
- Undefined: ILLEGAL returns to FETCH as above, illegal_instr is constant 0 and funct3_b2 is ignored.

Test Plan:
- Reset, then add (op=0110011) with mem_ready=1 → states FETCH, DECODE, EXEC_R, ALUWB. reg_write=1 only in cycle 4, with result_src=00. instret 0→1.
- Load (op=0000011) with mem_ready=0 for 2 cycles in MEMREAD → 7 cycles total. reg_write=1 with result_src=01 in the final cycle.
- Store with mem_ready held low 3 cycles → mem_write=1 for 4 consecutive cycles with adr_src=1. reg_write is never asserted.
- Branch (op=1100011) with branch_taken=1 → pc_write=1 in the BRANCH cycle. With branch_taken=0, pc_write stays 0 there. Both take 3 cycles.
- JALR → sequence FETCH, DECODE, JALR, JAL, ALUWB. pc_write=1 in the JAL cycle. reg_write=1 in ALUWB.
- op=1111111 → ILLEGAL, instret unchanged. Without the macro, FETCH follows. With ILLEGAL_TRAP_EN, illegal_instr=1 holds until rst_n=0 restores FETCH.
